// File: rtl/pll_lock_sequencer_if.sv
// PLL sequencer signal bundle: lock/restart inputs and the PLL/core reset controls.
// The master side is the sequencer; the slave side is whoever supplies lock and restart.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       fault;
  logic [2:0] retry_count;

  modport master (
    input  pll_locked,
    input  restart,
    output pll_rst,
    output core_reset_n,
    output ready,
    output fault,
    output retry_count
  );

  modport slave (
    output pll_locked,
    output restart,
    input  pll_rst,
    input  core_reset_n,
    input  ready,
    input  fault,
    input  retry_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences the board PLL: pulses its reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases the core reset for the derived clock domains.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 7,
  parameter int CNT_W        = 17
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_lock_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       retry_q;
  logic [2:0]       retry_nx;
  logic [2:0]       retry_inc;
  logic             lock_meta;
  logic             lock_s;

  // pll_locked comes from the PLL's own analog loop, so it is treated as fully asynchronous.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_ASSERT;
      cnt              <= '0;
      retry_q          <= '0;
      bus.pll_rst      <= 1'b1;
      bus.core_reset_n <= 1'b0;
      bus.ready        <= 1'b0;
      bus.fault        <= 1'b0;
    end else begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      retry_q          <= retry_nx;
      bus.pll_rst      <= (state_nx == ST_ASSERT) || (state_nx == ST_FAULT);
      bus.core_reset_n <= (state_nx == ST_RUN);
      bus.ready        <= (state_nx == ST_RUN);
      bus.fault        <= (state_nx == ST_FAULT);
    end
  end

  assign bus.retry_count = retry_q;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CNT_ONE;
    retry_nx  = retry_q;
    retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 3'd1;

    if (bus.restart) begin
      state_nx = ST_ASSERT;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == RST_LAST) begin
            state_nx = ST_WAIT_LOCK;
            cnt_nx   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = ST_STABLE;
            cnt_nx   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nx = retry_inc;
            state_nx = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_ASSERT;
            cnt_nx   = '0;
          end
        end
        // A lock drop while qualifying is not a timeout; the wait window simply restarts.
        ST_STABLE: begin
          if (!lock_s) begin
            state_nx = ST_WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
            retry_nx = '0;
          end
        end
        ST_RUN: begin
          cnt_nx = '0;
          if (!lock_s) begin
            state_nx = ST_ASSERT;
          end
        end
        ST_FAULT: begin
          cnt_nx = '0;
        end
        default: begin
          state_nx = ST_ASSERT;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule
